mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port instruction/data RAM between the fetch side (IF stage) and the load/store side (MEM stage) of the multi-cycle CPU. Each requester issues a request and holds it until a one-cycle acknowledge. The arbiter presents one access at a time to the RAM, waits out the fixed read latency, and returns read data to the owning port. It replaces the fixed IF_WAIT/MEM_WAIT slots in the stage sequencer with a handshake, so fetch and data accesses can later overlap in a pipelined core.

## Interface
- ADDR_W, 15, word-address width
- DATA_W, 32, data width
- RD_LATENCY, 2, cycles from address presented to mem_rdata valid; legal range 1..4
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  ADDR_W  instruction address, stable while i_req is high
- i_rdata  out  DATA_W  instruction read data, valid from the i_ack cycle until the next instruction completion
- i_ack  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  ADDR_W  data address, stable while d_req is high
- d_wdata  in  DATA_W  write data, stable while d_req is high
- d_rdata  out  DATA_W  data read result, valid from the d_ack cycle until the next data read completion
- d_ack  out  1  one-cycle completion pulse, data port
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** sample i_req/d_req.
  - Neither high: remain in IDLE.
  - Otherwise grant one port and record it as owner and last_grant.
  - Latch its address into mem_addr; for a data write, also latch d_wdata into mem_wdata and set mem_we.
  - Go to ISSUE.
- **ISSUE:** the address is on the RAM.
  - Write: mem_we is high for exactly this cycle; go to DONE.
  - Read: mem_we is low; go to WAIT with the counter loaded to RD_LATENCY-1.
- **WAIT:** the counter decrements each cycle.
  - On the cycle mem_rdata is valid (RD_LATENCY cycles after ISSUE), capture it into the owner's rdata register and go to DONE.
- **DONE:** assert the owner's ack for one cycle; go to IDLE.
- Arbitration when both requests are high in IDLE is set under Configuration. A single pending request is always granted.
- Instruction port is read-only; i_req never produces mem_we.
- mem_addr and mem_wdata hold their last values while idle. mem_we is 0 outside ISSUE-for-write.
- Requesters drop req on the edge ending the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- Reset values:
  - state = IDLE, counter = 0, last_grant = instruction.
  - i_ack, d_ack, mem_we, busy = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- Reset asserted mid-transaction: aborts immediately (asynchronous). mem_we drops without waiting for an edge, no ack is issued, and the aborted requester must re-request.

## Timing
- Request sampled high in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - Read: mem_rdata valid at cycle 1+RD_LATENCY; ack at cycle 2+RD_LATENCY.
  - Write: ack at cycle 2.
- Throughput:
  - one read per RD_LATENCY+3 cycles
  - one write per 3 cycles
  - the extra cycle in each is the mandatory IDLE between transactions
- Back-to-back contention: the losing port enters ISSUE 2 cycles after the winner's ack.
- Acks are never simultaneous; at most one of i_ack/d_ack is high in any cycle.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Undefined: fixed priority, data port over instruction port. The instruction port can be starved while d_req stays asserted.
- Defined: round-robin. On simultaneous requests, the port not recorded in last_grant wins. After reset the data port wins the first tie.

## Test plan
- Reset, then i_req with i_addr=0x0010 at cycle 0, RAM model returning 0xDEADBEEF, RD_LATENCY=2 -> mem_addr=0x0010 at cycle 1, i_ack high only at cycle 4, i_rdata=0xDEADBEEF, mem_we never high.
- d_req, d_we=1, d_addr=0x0100, d_wdata=0x12345678 at cycle 0 -> mem_we high only at cycle 1 with mem_addr=0x0100 and mem_wdata=0x12345678; d_ack at cycle 2; i_ack stays 0.
- Fixed priority: i_req (0x0020) and d_req read (0x0200) both at cycle 0 -> d_ack at cycle 4; ISSUE with mem_addr=0x0020 at cycle 6; i_ack at cycle 9.
- ARB_ROUND_ROBIN_EN defined: both ports continuously re-requesting reads for 4 transactions -> ack order d, i, d, i with no port receiving two consecutive grants.
- reset pulsed during WAIT of a read -> busy=0 and both acks 0 immediately; no ack is issued for the aborted access; a following i_req completes in the normal 4 cycles.
- RD_LATENCY=1, d read of 0x7FFF returning 0xA5A5A5A5 -> d_ack at cycle 3, d_rdata=0xA5A5A5A5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port RAM between the instruction-fetch port (read-only)
// and the load/store data port. Each port raises req and holds it, together
// with its address/data, until a one-cycle ack. Only one access is on the RAM
// at a time:
//   IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE
// Read data is captured exactly RD_LATENCY cycles after the ISSUE cycle and
// is held in the owning port's rdata register until that port's next read.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  undefined: data port wins every tie (fixed priority).
//                       defined:   the port that did not win last time wins
//                                  a tie; the data port wins the first tie
//                                  after reset.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   i_req/i_addr       instruction read request and address
//   i_rdata/i_ack      instruction read data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, 1=write, address, write data
//   d_rdata/d_ack      data read result, one-cycle completion pulse
//   mem_addr/mem_wdata/mem_we  registered RAM controls
//   mem_rdata          RAM read data (valid RD_LATENCY cycles after ISSUE)
//   busy               high whenever an access is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2    // legal range 1..4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // WAIT counts down from RD_LATENCY-1 to 0; the cycle it reads 0 is the
  // cycle mem_rdata is valid.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

  logic [1:0]        state_reg;
  logic [1:0]        count_reg;
  logic              owner_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_we_reg;
  logic [DATA_W-1:0] i_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              grant_d_next;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_reg;

  // On a tie the port that lost last time wins.
  always_comb begin
    grant_d_next = d_req && (!i_req || (last_grant_reg == OWN_I));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= OWN_I;
    end else if ((state_reg == ST_IDLE) && (i_req || d_req)) begin
      last_grant_reg <= grant_d_next;
    end
  end
`else
  // Data port always wins a tie; the instruction port may be starved.
  always_comb begin
    grant_d_next = d_req;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 2'd0;
      owner_reg     <= OWN_I;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_req || d_req) begin
            state_reg <= ST_ISSUE;
            owner_reg <= grant_d_next;
            if (grant_d_next) begin
              mem_addr_reg <= d_addr;
              if (d_we) begin
                mem_wdata_reg <= d_wdata;
                mem_we_reg    <= 1'b1;
              end
            end else begin
              mem_addr_reg <= i_addr;
            end
          end
        end
        ST_ISSUE: begin
          // mem_we doubles as the "this access is a write" flag here.
          mem_we_reg <= 1'b0;
          if (mem_we_reg) begin
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_WAIT;
            count_reg <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (count_reg == 2'd0) begin
            if (owner_reg == OWN_D) begin
              d_rdata_reg <= mem_rdata;
            end else begin
              i_rdata_reg <= mem_rdata;
            end
            state_reg <= ST_DONE;
          end else begin
            count_reg <= count_reg - 2'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Acks are decoded from state so an asynchronous reset clears them at once.
  assign i_ack     = (state_reg == ST_DONE) && (owner_reg == OWN_I);
  assign d_ack     = (state_reg == ST_DONE) && (owner_reg == OWN_D);
  assign busy      = (state_reg != ST_IDLE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule
